// File: rtl/ad9958_spi_responder.sv
// rtl/ad9958_spi_responder.sv - AD9958 serial-port responder with double-buffered registers
module ad9958_spi_responder #(
    parameter logic [7:0] CSR_RESET = 8'hF0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        master_reset,
    input  logic        io_update,
    input  logic [3:0]  sdio,
    output logic [7:0]  csr,
    output logic [23:0] fr1,
    output logic [23:0] cfr_ch0,
    output logic [23:0] cfr_ch1,
    output logic [31:0] ftw_ch0,
    output logic [31:0] ftw_ch1,
    output logic [9:0]  asf_ch0,
    output logic [9:0]  asf_ch1,
    output logic        asf_en_ch0,
    output logic        asf_en_ch1,
    output logic        write_strobe,
    output logic [4:0]  write_addr,
    output logic        update_pulse,
    output logic        frame_error
);

    localparam logic [4:0] A_CSR   = 5'h00;
    localparam logic [4:0] A_FR1   = 5'h01;
    localparam logic [4:0] A_CFR   = 5'h03;
    localparam logic [4:0] A_CFTW0 = 5'h04;
    localparam logic [4:0] A_ACR   = 5'h06;

    typedef enum logic [1:0] {S_IDLE, S_INSTR, S_DATA, S_SKIP} state_t;

    // Data length in bytes per register address; zero marks an unsupported address.
    function automatic logic [2:0] len_of(input logic [4:0] a);
        case (a)
            5'h00:   len_of = 3'd1;
            5'h01:   len_of = 3'd3;
            5'h02:   len_of = 3'd2;
            5'h03:   len_of = 3'd3;
            5'h04:   len_of = 3'd4;
            5'h05:   len_of = 3'd2;
            5'h06:   len_of = 3'd3;
            default: len_of = 3'd0;
        endcase
    endfunction

    logic [2:0] sclk_q, iou_q;
    logic [1:0] cs_q, mr_q;
    logic [3:0] sdio_q1, sdio_q2;
    logic       sclk_rise, iou_rise, cs_high, mr_sync;

    state_t      state;
    logic [31:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic [4:0]  addr_q;
    logic        rd_q;
    logic [2:0]  len_q;

    logic [2:0]  step;
    logic [5:0]  width, bits_after;
    logic [31:0] shift_next, word;
    logic        word_done, commit_write;

    logic [23:0]       fr1_buf, fr1_n;
    logic [1:0][23:0]  cfr_buf, cfr_n;
    logic [1:0][31:0]  ftw_buf, ftw_n;
    logic [1:0][9:0]   asf_buf, asf_n;
    logic [1:0]        asf_en_buf, asf_en_n;

    // Two-flop synchronizers; the third sclk/io_update flop provides rising-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q  <= '0;
            iou_q   <= '0;
            cs_q    <= '1;
            mr_q    <= '0;
            sdio_q1 <= '0;
            sdio_q2 <= '0;
        end else begin
            sclk_q  <= {sclk_q[1:0], sclk};
            iou_q   <= {iou_q[1:0], io_update};
            cs_q    <= {cs_q[0], cs_n};
            mr_q    <= {mr_q[0], master_reset};
            sdio_q1 <= sdio;
            sdio_q2 <= sdio_q1;
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign iou_rise  = iou_q[1] & ~iou_q[2];
    assign cs_high   = cs_q[1];
    assign mr_sync   = mr_q[1];

    // Shift datapath: bits per edge and order follow the live CSR; LSB-first words are realigned.
    always_comb begin
        case (csr[2:1])
            2'b11:   step = 3'd4;
            2'b10:   step = 3'd2;
            default: step = 3'd1;
        endcase
        width      = (state == S_DATA) ? {len_q, 3'b000} : 6'd8;
        bits_after = {1'b0, bit_cnt} + {3'b000, step};
        shift_next = shift_reg;
        if (csr[0]) begin
            case (step)
                3'd4:    shift_next = {sdio_q2, shift_reg[31:4]};
                3'd2:    shift_next = {sdio_q2[1:0], shift_reg[31:2]};
                default: shift_next = {sdio_q2[0], shift_reg[31:1]};
            endcase
            word = shift_next >> (6'd32 - width);
        end else begin
            case (step)
                3'd4:    shift_next = {shift_reg[27:0], sdio_q2};
                3'd2:    shift_next = {shift_reg[29:0], sdio_q2[1:0]};
                default: shift_next = {shift_reg[30:0], sdio_q2[0]};
            endcase
            word = shift_next;
        end
        word_done    = sclk_rise && (state == S_INSTR || state == S_DATA) && (bits_after == width);
        commit_write = word_done && (state == S_DATA) && !rd_q && !cs_high;
    end

    // Next buffer contents; io_update copies these so a same-cycle commit bypasses to the outputs.
    always_comb begin
        fr1_n    = fr1_buf;
        cfr_n    = cfr_buf;
        ftw_n    = ftw_buf;
        asf_n    = asf_buf;
        asf_en_n = asf_en_buf;
        if (commit_write) begin
            case (addr_q)
                A_FR1: fr1_n = word[23:0];
                A_CFR: begin
                    for (int ch = 0; ch < 2; ch++)
                        if (csr[6+ch]) cfr_n[ch] = word[23:0];
                end
                A_CFTW0: begin
                    for (int ch = 0; ch < 2; ch++)
                        if (csr[6+ch]) ftw_n[ch] = word;
                end
                A_ACR: begin
                    for (int ch = 0; ch < 2; ch++)
                        if (csr[6+ch]) begin
                            asf_n[ch]    = word[9:0];
                            asf_en_n[ch] = word[12];
                        end
                end
                default: ;
            endcase
        end
    end

    // Frame FSM, CSR, buffers, active registers and strobes; master_reset overrides everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            len_q        <= '0;
            csr          <= CSR_RESET;
            fr1_buf      <= '0;
            cfr_buf      <= '0;
            ftw_buf      <= '0;
            asf_buf      <= '0;
            asf_en_buf   <= '0;
            fr1          <= '0;
            cfr_ch0      <= '0;
            cfr_ch1      <= '0;
            ftw_ch0      <= '0;
            ftw_ch1      <= '0;
            asf_ch0      <= '0;
            asf_ch1      <= '0;
            asf_en_ch0   <= 1'b0;
            asf_en_ch1   <= 1'b0;
            write_strobe <= 1'b0;
            write_addr   <= '0;
            update_pulse <= 1'b0;
            frame_error  <= 1'b0;
        end else if (mr_sync) begin
            state        <= S_IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            len_q        <= '0;
            csr          <= CSR_RESET;
            fr1_buf      <= '0;
            cfr_buf      <= '0;
            ftw_buf      <= '0;
            asf_buf      <= '0;
            asf_en_buf   <= '0;
            fr1          <= '0;
            cfr_ch0      <= '0;
            cfr_ch1      <= '0;
            ftw_ch0      <= '0;
            ftw_ch1      <= '0;
            asf_ch0      <= '0;
            asf_ch1      <= '0;
            asf_en_ch0   <= 1'b0;
            asf_en_ch1   <= 1'b0;
            write_strobe <= 1'b0;
            write_addr   <= '0;
            update_pulse <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            write_strobe <= 1'b0;
            update_pulse <= 1'b0;
            frame_error  <= 1'b0;
            fr1_buf      <= fr1_n;
            cfr_buf      <= cfr_n;
            ftw_buf      <= ftw_n;
            asf_buf      <= asf_n;
            asf_en_buf   <= asf_en_n;
            if (iou_rise) begin
                fr1          <= fr1_n;
                cfr_ch0      <= cfr_n[0];
                cfr_ch1      <= cfr_n[1];
                ftw_ch0      <= ftw_n[0];
                ftw_ch1      <= ftw_n[1];
                asf_ch0      <= asf_n[0];
                asf_ch1      <= asf_n[1];
                asf_en_ch0   <= asf_en_n[0];
                asf_en_ch1   <= asf_en_n[1];
                update_pulse <= 1'b1;
            end
            if (cs_high) begin
                if ((state == S_INSTR || state == S_DATA) && bit_cnt != 5'd0)
                    frame_error <= 1'b1;
                state     <= S_IDLE;
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state     <= S_INSTR;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                    S_INSTR, S_DATA: begin
                        if (sclk_rise) begin
                            if (word_done) begin
                                bit_cnt   <= '0;
                                shift_reg <= '0;
                                if (state == S_INSTR) begin
                                    if (len_of(word[4:0]) == 3'd0) begin
                                        frame_error <= 1'b1;
                                        state       <= S_SKIP;
                                    end else begin
                                        addr_q      <= word[4:0];
                                        rd_q        <= word[7];
                                        len_q       <= len_of(word[4:0]);
                                        frame_error <= word[7];
                                        state       <= S_DATA;
                                    end
                                end else begin
                                    state <= S_INSTR;
                                    if (!rd_q) begin
                                        write_strobe <= 1'b1;
                                        write_addr   <= addr_q;
                                        if (addr_q == A_CSR) csr <= word[7:0];
                                    end
                                end
                            end else begin
                                bit_cnt   <= bits_after[4:0];
                                shift_reg <= shift_next;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad9958_spi_responder.sv
// tb/tb_ad9958_spi_responder.sv - scoreboard bench for ad9958_spi_responder
module tb_ad9958_spi_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        master_reset = 1'b0;
    logic        io_update = 1'b0;
    logic [3:0]  sdio = 4'h0;
    logic [7:0]  csr;
    logic [23:0] fr1, cfr_ch0, cfr_ch1;
    logic [31:0] ftw_ch0, ftw_ch1;
    logic [9:0]  asf_ch0, asf_ch1;
    logic        asf_en_ch0, asf_en_ch1;
    logic        write_strobe, update_pulse, frame_error;
    logic [4:0]  write_addr;

    ad9958_spi_responder dut (
        .clock(clock), .reset_n(reset_n), .sclk(sclk), .cs_n(cs_n),
        .master_reset(master_reset), .io_update(io_update), .sdio(sdio),
        .csr(csr), .fr1(fr1), .cfr_ch0(cfr_ch0), .cfr_ch1(cfr_ch1),
        .ftw_ch0(ftw_ch0), .ftw_ch1(ftw_ch1), .asf_ch0(asf_ch0), .asf_ch1(asf_ch1),
        .asf_en_ch0(asf_en_ch0), .asf_en_ch1(asf_en_ch1),
        .write_strobe(write_strobe), .write_addr(write_addr),
        .update_pulse(update_pulse), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;   // 0 write strobe, 1 frame error, 2 update
        logic [4:0]  addr;
        logic [7:0]  csr;
        logic [23:0] fr1;
        logic [23:0] cfr [2];
        logic [31:0] ftw [2];
        logic [23:0] acr [2];
    } ev_t;

    ev_t q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference register file: whole register words, buffered and active.
    logic [7:0]  m_csr;
    logic [23:0] m_fr1_b, m_fr1_a;
    logic [23:0] m_cfr_b [2], m_cfr_a [2];
    logic [31:0] m_ftw_b [2], m_ftw_a [2];
    logic [23:0] m_acr_b [2], m_acr_a [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int len_of(input logic [4:0] a);
        case (a)
            5'h00: return 1;
            5'h01: return 3;
            5'h02: return 2;
            5'h03: return 3;
            5'h04: return 4;
            5'h05: return 2;
            5'h06: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int k_of(input logic [7:0] c);
        if (c[2:1] == 2'b11) return 4;
        if (c[2:1] == 2'b10) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        m_csr = 8'hF0;
        m_fr1_b = '0; m_fr1_a = '0;
        for (int i = 0; i < 2; i++) begin
            m_cfr_b[i] = '0; m_cfr_a[i] = '0;
            m_ftw_b[i] = '0; m_ftw_a[i] = '0;
            m_acr_b[i] = '0; m_acr_a[i] = '0;
        end
    endtask

    task automatic model_commit(input logic [4:0] a, input logic [31:0] d);
        case (a)
            5'h00: m_csr = d[7:0];
            5'h01: m_fr1_b = d[23:0];
            5'h03: for (int ch = 0; ch < 2; ch++) if (m_csr[6+ch]) m_cfr_b[ch] = d[23:0];
            5'h04: for (int ch = 0; ch < 2; ch++) if (m_csr[6+ch]) m_ftw_b[ch] = d;
            5'h06: for (int ch = 0; ch < 2; ch++) if (m_csr[6+ch]) m_acr_b[ch] = d[23:0];
            default: ;
        endcase
    endtask

    task automatic model_update();
        m_fr1_a = m_fr1_b;
        m_cfr_a = m_cfr_b;
        m_ftw_a = m_ftw_b;
        m_acr_a = m_acr_b;
    endtask

    task automatic push_ev(input int kind, input logic [4:0] a);
        ev_t e;
        e.kind = kind; e.addr = a; e.csr = m_csr; e.fr1 = m_fr1_a;
        e.cfr = m_cfr_a; e.ftw = m_ftw_a; e.acr = m_acr_a;
        q.push_back(e);
    endtask

    // Monitor: every DUT pulse pops the next expected event and compares it.
    task automatic pop_check(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_pulse: got pulse kind %0d, expected none", kind);
            return;
        end
        e = q.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        if (kind == 0) begin
            check("write_addr", 32'(write_addr), 32'(e.addr));
            check("csr_at_strobe", 32'(csr), 32'(e.csr));
        end
        if (kind == 2) begin
            check("upd_fr1", 32'(fr1), 32'(e.fr1));
            check("upd_cfr_ch0", 32'(cfr_ch0), 32'(e.cfr[0]));
            check("upd_cfr_ch1", 32'(cfr_ch1), 32'(e.cfr[1]));
            check("upd_ftw_ch0", ftw_ch0, e.ftw[0]);
            check("upd_ftw_ch1", ftw_ch1, e.ftw[1]);
            check("upd_asf_ch0", 32'(asf_ch0), 32'(e.acr[0][9:0]));
            check("upd_asf_ch1", 32'(asf_ch1), 32'(e.acr[1][9:0]));
            check("upd_asf_en_ch0", 32'(asf_en_ch0), 32'(e.acr[0][12]));
            check("upd_asf_en_ch1", 32'(asf_en_ch1), 32'(e.acr[1][12]));
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (write_strobe) pop_check(0);
            if (frame_error)  pop_check(1);
            if (update_pulse) pop_check(2);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_outputs();
        check("csr", 32'(csr), 32'(m_csr));
        check("fr1", 32'(fr1), 32'(m_fr1_a));
        check("cfr_ch0", 32'(cfr_ch0), 32'(m_cfr_a[0]));
        check("cfr_ch1", 32'(cfr_ch1), 32'(m_cfr_a[1]));
        check("ftw_ch0", ftw_ch0, m_ftw_a[0]);
        check("ftw_ch1", ftw_ch1, m_ftw_a[1]);
        check("asf_ch0", 32'(asf_ch0), 32'(m_acr_a[0][9:0]));
        check("asf_ch1", 32'(asf_ch1), 32'(m_acr_a[1][9:0]));
        check("asf_en_ch0", 32'(asf_en_ch0), 32'(m_acr_a[0][12]));
        check("asf_en_ch1", 32'(asf_en_ch1), 32'(m_acr_a[1][12]));
    endtask

    // Serialise nbits of val in groups of k; MSB-first sends the top group first, top pin = group MSB.
    task automatic send_bits(input logic [31:0] val, input int nbits, input int k,
                             input bit lsb, input bit iou_last);
        for (int i = 0; i < nbits / k; i++) begin
            logic [3:0] g, pins;
            if (lsb) g = 4'((val >> (i * k)) & 32'((1 << k) - 1));
            else     g = 4'((val >> (nbits - (i + 1) * k)) & 32'((1 << k) - 1));
            pins = 4'($urandom);
            for (int b = 0; b < k; b++) pins[b] = g[b];
            sdio = pins;
            tick(3);
            sclk = 1'b1;
            if (iou_last && i == nbits / k - 1) io_update = 1'b1;
            tick(3);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        tick(3);
    endtask

    task automatic cs_end();
        tick(2);
        cs_n = 1'b1;
        io_update = 1'b0;
        tick(6);
        check_outputs();
    endtask

    task automatic write_frame(input logic [4:0] a, input logic [31:0] d, input bit iou);
        int k = k_of(m_csr);
        bit lsb = m_csr[0];
        int len = len_of(a);
        logic [31:0] dm = (len == 4) ? d : (d & ((32'd1 << (8 * len)) - 1));
        model_commit(a, dm);
        push_ev(0, a);
        if (iou) begin
            model_update();
            push_ev(2, 5'd0);
        end
        send_bits({27'd0, a}, 8, k, lsb, 1'b0);
        send_bits(dm, 8 * len, k, lsb, iou);
        if (iou) begin
            tick(4);
            io_update = 1'b0;
        end
    endtask

    task automatic read_frame(input logic [4:0] a);
        int k = k_of(m_csr);
        push_ev(1, a);
        send_bits({24'd0, 1'b1, 2'b00, a}, 8, k, m_csr[0], 1'b0);
        send_bits($urandom, 8 * len_of(a), k, m_csr[0], 1'b0);
    endtask

    task automatic bad_frame(input logic [4:0] a);
        int k = k_of(m_csr);
        push_ev(1, a);
        send_bits({24'd0, 1'($urandom), 2'b00, a}, 8, k, m_csr[0], 1'b0);
        send_bits($urandom, 8, k, m_csr[0], 1'b0);
    endtask

    task automatic partial_frame(input logic [4:0] a, input int nbits);
        int k = k_of(m_csr);
        send_bits({27'd0, a}, 8, k, m_csr[0], 1'b0);
        send_bits($urandom, nbits, k, m_csr[0], 1'b0);
        push_ev(1, a);
    endtask

    task automatic io_pulse();
        model_update();
        push_ev(2, 5'd0);
        io_update = 1'b1;
        tick(5);
        io_update = 1'b0;
        tick(5);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check_outputs();
        check("reset_write_addr", 32'(write_addr), 32'd0);
        check("reset_pulses", {29'd0, write_strobe, update_pulse, frame_error}, 32'd0);

        // 1-bit MSB-first CSR write switches to 4-bit LSB-first
        cs_begin(); write_frame(5'h00, 32'hF7, 1'b0); cs_end();

        // 4-bit LSB-first CFTW0 stays buffered until io_update
        cs_begin(); write_frame(5'h00, 32'h47, 1'b0); write_frame(5'h04, 32'h12345678, 1'b0); cs_end();
        io_pulse();
        check("ftw_ch0_after_update", ftw_ch0, 32'h12345678);

        // Both channels enabled, ACR, then update
        cs_begin(); write_frame(5'h00, 32'hC7, 1'b0); write_frame(5'h06, 32'h0013FF, 1'b0); cs_end();
        io_pulse();

        // Unknown address then ignored edges; truncated CFTW0
        cs_begin(); bad_frame(5'h1F); cs_end();
        cs_begin(); partial_frame(5'h04, 24); cs_end();

        // FR1 commit coinciding with io_update
        cs_begin(); write_frame(5'h01, 32'h9C0000, 1'b1); cs_end();
        check("fr1_bypass", 32'(fr1), 32'h9C0000);

        // master_reset mid-frame
        cs_begin();
        send_bits(32'h04, k_of(m_csr), k_of(m_csr), m_csr[0], 1'b0);
        master_reset = 1'b1; tick(6);
        cs_n = 1'b1; tick(6);
        master_reset = 1'b0; tick(6);
        model_reset();
        check_outputs();
        check("mr_write_addr", 32'(write_addr), 32'd0);
        cs_begin(); write_frame(5'h01, 32'hA5C3E1, 1'b0); cs_end();
        io_pulse();

        // Randomized traffic
        for (int op = 0; op < 40; op++) begin
            int sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                int nfr = $urandom_range(1, 3);
                cs_begin();
                for (int f = 0; f < nfr; f++)
                    write_frame(5'($urandom_range(0, 6)), $urandom, ($urandom_range(0, 4) == 0));
                cs_end();
            end else if (sel == 6) begin
                io_pulse();
            end else if (sel == 7) begin
                cs_begin();
                read_frame(5'($urandom_range(0, 6)));
                write_frame(5'($urandom_range(1, 6)), $urandom, 1'b0);
                cs_end();
            end else if (sel == 8) begin
                logic [4:0] a = 5'($urandom_range(0, 6));
                int k = k_of(m_csr);
                cs_begin();
                partial_frame(a, k * $urandom_range(1, 8 * len_of(a) / k - 1));
                cs_end();
            end else begin
                cs_begin(); bad_frame(5'($urandom_range(7, 31))); cs_end();
            end
        end

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
